// File: rtl/piso_sample_serializer.sv
// piso_sample_serializer: DEPTH-sample frame load, one-sample-per-handshake serial out; PISO_BITREV_EN selects bit-reversed order
module piso_sample_serializer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WIDTH*DEPTH-1:0]    d_in,
    output logic                      load_ready,
    output logic signed [WIDTH-1:0]   d_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      done
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH*DEPTH-1:0] frame_q, frame_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic done_q, done_d;
    function automatic logic [CNT_W-1:0] idx(input logic [CNT_W-1:0] c);
`ifdef PISO_BITREV_EN
        for (int i = 0; i < CNT_W; i++) idx[i] = c[CNT_W-1-i];
`else
        idx = c;
`endif
    endfunction
    assign cnt_inc = cnt_q + CNT_W'(1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        d_out_d = d_out_q;
        done_d  = 1'b0;
        if (state_q == IDLE && load) begin
            frame_d = d_in;
            cnt_d   = '0;
            d_out_d = d_in[WIDTH-1:0];
            state_d = SEND;
        end else if (state_q == SEND && out_ready) begin
            if (cnt_q == CNT_W'(DEPTH-1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d   = cnt_inc;
                d_out_d = frame_q[WIDTH*idx(cnt_inc) +: WIDTH];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            d_out_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_out_q <= d_out_d;
            done_q  <= done_d;
        end
    end
    always_ff @(posedge clk) frame_q <= frame_d;
    assign load_ready = state_q == IDLE;
    assign out_valid  = state_q == SEND;
    assign busy       = state_q == SEND;
    assign done       = done_q;
    assign d_out      = d_out_q;
endmodule
